// File: rtl/beat_tick_gen_pkg.sv
// beat_tick_pkg: state encoding and beat width shared by beat_tick_gen.
// PAUSE exists only when BEAT_TICK_GEN_PAUSE_EN is defined.
package beat_tick_pkg;
  localparam int BEAT_W = 4;
`ifdef BEAT_TICK_GEN_PAUSE_EN
  typedef enum logic [1:0] {IDLE, ARM, RUN, PAUSE} state_e;
`else
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;
`endif
endpackage

// File: rtl/beat_tick_gen_edge_sync.sv
// edge_sync: 2-flop synchronizer plus previous-value flop producing a rising-edge strobe.
// rise_o is masked on resync and until the chain has refilled after reset or a source change.
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic bit_i,
  input  logic resync_i,
  output logic rise_o
);
  logic s1_q, s2_q, prev_q;
  logic [2:0] ok_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      ok_q   <= 3'b000;
    end else begin
      s1_q   <= bit_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      ok_q   <= resync_i ? 3'b000 : {ok_q[1:0], 1'b1};
    end
  end
  // ok_q[2] rises only once stale chain contents have fully drained into prev_q
  assign rise_o = s2_q & ~prev_q & ok_q[2] & ~resync_i;
endmodule

// File: rtl/beat_tick_gen.sv
// beat_tick_gen: beat/bar tick generator driven by a selectable divided-clock bit.
// Optional pause support is enabled by defining BEAT_TICK_GEN_PAUSE_EN.
module beat_tick_gen
  import beat_tick_pkg::*;
#(
  parameter int BEATS_PER_BAR = 4,
  parameter int CNT_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       divided_clocks,
  input  logic [4:0]        rate_sel,
  input  logic              start,
  input  logic              stop,
`ifdef BEAT_TICK_GEN_PAUSE_EN
  input  logic              pause,
`endif
  output logic              tick,
  output logic [BEAT_W-1:0] beat,
  output logic              bar_tick,
  output logic [CNT_W-1:0]  bar_count,
  output logic              running
);
  state_e            state_q;
  logic [4:0]        rsel_q;
  logic              tick_q, bar_tick_q, run_q, rise, last;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  bar_q;
  edge_sync u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .bit_i    (divided_clocks[rate_sel]),
    .resync_i (rate_sel != rsel_q),
    .rise_o   (rise)
  );
  assign last = beat_q == BEAT_W'(BEATS_PER_BAR - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rsel_q     <= '0;
      tick_q     <= 1'b0;
      bar_tick_q <= 1'b0;
      run_q      <= 1'b0;
      beat_q     <= '0;
      bar_q      <= '0;
    end else begin
      rsel_q     <= rate_sel;
      tick_q     <= 1'b0;
      bar_tick_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        run_q   <= 1'b0;
        beat_q  <= '0;
        bar_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (start) state_q <= ARM;
          ARM: if (rise) begin
            state_q    <= RUN;
            run_q      <= 1'b1;
            tick_q     <= 1'b1;
            bar_tick_q <= 1'b1;
            beat_q     <= '0;
          end
          RUN:
`ifdef BEAT_TICK_GEN_PAUSE_EN
            if (pause) state_q <= PAUSE;
            else
`endif
            if (rise) begin
              tick_q     <= 1'b1;
              bar_tick_q <= last;
              beat_q     <= last ? '0 : beat_q + BEAT_W'(1);
              bar_q      <= last ? bar_q + CNT_W'(1) : bar_q;
            end
`ifdef BEAT_TICK_GEN_PAUSE_EN
          PAUSE: if (!pause) state_q <= RUN;
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign tick      = tick_q;
  assign bar_tick  = bar_tick_q;
  assign beat      = beat_q;
  assign bar_count = bar_q;
  assign running   = run_q;
endmodule

// File: tb/tb_beat_tick_gen.sv
// tb_beat_tick_gen: directed + randomized checks of beat_tick_gen against a beat-count reference model.
module tb_beat_tick_gen;
  localparam int B = 4;
  localparam int W = 2;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, pause_v = 1'b0;
  logic [31:0] divided_clocks = '0;
  logic [4:0] rate_sel = 5'd3, rsel_v = 5'd3;
  logic tick, bar_tick, running;
  logic [3:0] beat;
  logic [W-1:0] bar_count;
  int vecs = 0, errs = 0;
  int cyc = 0, quiet = 0, hold = 0;
  logic src = 1'b0, src_prev = 1'b0, auto_src = 1'b0;
  int due_q[$];
  int ms = 0, k = 0, m_beat = 0, m_bars = 0;
  logic m_tick = 1'b0, m_bt = 1'b0, m_run = 1'b0;

  beat_tick_gen #(.BEATS_PER_BAR(B), .CNT_W(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .divided_clocks (divided_clocks),
    .rate_sel       (rate_sel),
    .start          (start),
    .stop           (stop),
`ifdef BEAT_TICK_GEN_PAUSE_EN
    .pause          (pause_v),
`endif
    .tick           (tick),
    .beat           (beat),
    .bar_tick       (bar_tick),
    .bar_count      (bar_count),
    .running        (running)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("bar_tick", 32'(bar_tick), 32'(m_bt));
    chk("beat", 32'(beat), 32'(m_beat));
    chk("bar_count", 32'(bar_count), 32'(m_bars));
    chk("running", 32'(running), 32'(m_run));
  endtask

  // Reference: k counts beats since arming; beat and bar follow by division.
  function automatic void give_tick();
    k++;
    m_tick = 1'b1;
    m_beat = (k - 1) % B;
    m_bt   = (m_beat == 0);
    m_bars = ((k - 1) / B) % (1 << W);
  endfunction

  function automatic void model_clk(input logic st, input logic sp, input logic ps, input logic e);
    m_tick = 1'b0;
    m_bt   = 1'b0;
    if (sp) begin
      ms = 0; k = 0; m_beat = 0; m_bars = 0; m_run = 1'b0;
    end else if (ms == 0) begin
      if (st) ms = 1;
    end else if (ms == 1) begin
      if (e) begin ms = 2; m_run = 1'b1; give_tick(); end
    end else if (ms == 2) begin
      if (ps) ms = 3;
      else if (e) give_tick();
    end else if (!ps) ms = 2;
  endfunction

  // One clock: drive inputs at negedge, advance model at posedge, compare 1ns later.
  task automatic step();
    logic [31:0] dc;
    logic e;
    @(negedge clock);
    if (rsel_v != rate_sel) quiet = 0;
    if (auto_src && quiet >= 5) begin
      if (hold == 0) begin src = ~src; hold = $urandom_range(1, 4); end
      else hold--;
    end
    // a rise applied before edge cyc shows as tick after edge cyc+2 (three clock edges)
    if (src && !src_prev && quiet >= 5) due_q.push_back(cyc + 2);
    dc = $urandom & 32'hFFFF_FF00;
    dc[rsel_v] = src;
    divided_clocks = dc;
    rate_sel = rsel_v;
    src_prev = src;
    quiet++;
    @(posedge clock);
    e = (due_q.size() > 0 && due_q[0] == cyc);
    if (e) void'(due_q.pop_front());
`ifdef BEAT_TICK_GEN_PAUSE_EN
    model_clk(start, stop, pause_v, e);
`else
    model_clk(start, stop, 1'b0, e);
`endif
    cyc++;
    #1 check_all();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_bar_tick", 32'(bar_tick), 0);
    chk("rst_beat", 32'(beat), 0);
    chk("rst_bar_count", 32'(bar_count), 0);
    chk("rst_running", 32'(running), 0);
    @(negedge clock);
    reset = 1'b0;
    due_q.delete();
    ms = 0; k = 0; m_beat = 0; m_bars = 0; m_run = 1'b0; m_tick = 1'b0; m_bt = 1'b0;
    quiet = 0;
    src_prev = src;
  endtask

  task automatic rise_once();
    src = 1'b0;
    repeat (2) step();
    src = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    bit found;
    do_reset();
    start = 1'b1;
    repeat (5) step();
    start = 1'b0;
    rise_once();
    chk("first_tick", 32'(tick), 1);
    chk("first_beat", 32'(beat), 0);
    chk("first_bar_tick", 32'(bar_tick), 1);
    chk("first_running", 32'(running), 1);
    auto_src = 1'b1;
    repeat (150) step();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (due_q.size() > 0 && due_q[0] == cyc) found = 1'b1;
      else step();
    end
    chk("stop_edge_found", 32'(found), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_tick", 32'(tick), 0);
    chk("stop_beat", 32'(beat), 0);
    chk("stop_bar_count", 32'(bar_count), 0);
    start = 1'b1;
    stop = 1'b1;
    repeat (6) step();
    chk("start_stop_idle", 32'(running), 0);
    stop = 1'b0;
    step();
    start = 1'b0;
    repeat (25) step();
    auto_src = 1'b0;
    src = 1'b0;
    repeat (6) step();
    rsel_v = 5'd5;
    src = 1'b1;
    repeat (6) step();
    src = 1'b0;
    repeat (3) step();
    src = 1'b1;
    repeat (3) step();
    chk("rate_change_tick", 32'(tick), 1);
    src = 1'b1;
    do_reset();
    start = 1'b1;
    repeat (8) step();
    start = 1'b0;
    chk("reset_high_no_run", 32'(running), 0);
    rise_once();
    chk("reset_high_fresh_tick", 32'(tick), 1);
`ifdef BEAT_TICK_GEN_PAUSE_EN
    repeat (2) rise_once();
    chk("pre_pause_beat", 32'(beat), 2);
    pause_v = 1'b1;
    repeat (3) rise_once();
    chk("pause_beat", 32'(beat), 2);
    chk("pause_running", 32'(running), 1);
    pause_v = 1'b0;
    rise_once();
    chk("resume_beat", 32'(beat), 3);
    chk("resume_tick", 32'(tick), 1);
`endif
    auto_src = 1'b1;
    repeat (200) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/beat_tick_gen.md
BEAT_TICK_GEN -- requirements
Module: beat_tick_gen

Interface
REQ-001 SHALL have parameter BEATS_PER_BAR, default 4, beats per bar (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of bar counter.
REQ-003 SHALL have port clock  input  1  sole clock; all flops on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port divided_clocks  input  32  free-running divider bus from the system clock divider.
REQ-006 SHALL have port rate_sel  input  5  index of divided_clocks bit used as beat source.
REQ-007 SHALL have port start  input  1  level; arms the generator.
REQ-008 SHALL have port stop  input  1  level; returns to IDLE.
REQ-009 SHALL have port pause  input  1  hold beats (present only with BEAT_TICK_GEN_PAUSE_EN).
REQ-010 SHALL have port tick  output  1  one-cycle pulse per beat.
REQ-011 SHALL have port beat  output  4  current beat index, 0..BEATS_PER_BAR-1.
REQ-012 SHALL have port bar_tick  output  1  one-cycle pulse coincident with tick when beat becomes 0.
REQ-013 SHALL have port bar_count  output  CNT_W  completed-bar counter.
REQ-014 SHALL have port running  output  1  high in RUN (and PAUSE).

Function
REQ-015 SHALL pass divided_clocks[rate_sel] through a 2-flop synchronizer, then a previous-value flop; rising edge = sync_out & ~prev.
REQ-016 SHALL register rate_sel; in any cycle where rate_sel differs from the registered copy, edge detection is suppressed and prev loads the current sync_out (no spurious tick).
REQ-017 SHALL assert tick (registered) exactly one cycle, with the source bit's rise-to-tick latency 3 clock cycles.
REQ-018 SHALL implement states IDLE, ARM, RUN (plus PAUSE when the macro is defined).
REQ-019 IDLE: tick=0, bar_tick=0, beat=0, bar_count=0, running=0; start=1 and stop=0 -> ARM.
REQ-020 ARM: first detected edge -> RUN, emitting tick=1, bar_tick=1, beat=0; bar_count unchanged.
REQ-021 RUN: each edge emits tick; beat increments; beat at BEATS_PER_BAR-1 wraps to 0 with bar_tick=1 and bar_count+1.
REQ-022 bar_count SHALL wrap from 2^CNT_W-1 to 0 silently.
REQ-023 stop=1 in any state -> IDLE next cycle, clearing beat and bar_count; stop beats start when both high.
REQ-024 start while ARM/RUN/PAUSE SHALL be ignored.
REQ-025 An edge coinciding with stop SHALL produce no tick.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE and clear all flops (sync chain, prev, registered rate_sel, outputs) to 0.
REQ-027 Deassertion mid-source-high SHALL not yield a tick until a fresh rising edge occurs after ARM.

Configuration
REQ-028 With BEAT_TICK_GEN_PAUSE_EN defined: pause port exists; pause=1 in RUN -> PAUSE; edges ignored, beat/bar_count hold, running=1; pause=0 -> RUN; resume at next new edge, no catch-up ticks; stop overrides pause.
REQ-029 Without BEAT_TICK_GEN_PAUSE_EN: no pause port, no PAUSE state; behaviour otherwise identical.

Structure
REQ-030 Package beat_tick_pkg SHALL hold the state enum typedef and BEAT_W=4 constant.
REQ-031 Sub-module edge_sync SHALL contain the 2-flop synchronizer, prev flop and rising-edge output, with a resync input for REQ-016.

Verification
REQ-032 reset, start=1, rate_sel=3, toggling bit 3 -> first tick 3 cycles after rise, beat=0, bar_tick=1, running=1.
REQ-033 RUN with BEATS_PER_BAR=4, 9 edges -> beat sequence 0,1,2,3,0,1,2,3,0; bar_tick on edges 1,5,9; bar_count=2.
REQ-034 CNT_W=2, 17 edges -> bar_count wraps 3->0 at edge 17.
REQ-035 change rate_sel 3->5 while new bit is high, old low -> no tick that cycle; next tick on next bit-5 rise.
REQ-036 start=1 and stop=1 together in IDLE -> stays IDLE; stop during RUN with coincident edge -> no tick, beat=0, bar_count=0.
REQ-037 (macro) pause for 3 source edges -> no ticks, beat holds at 2; release -> next edge gives beat=3.
